// File: rtl/clk_div_monitor.sv
// Clock-divider monitor: measures the high and low phase lengths of an asynchronous divided
// clock in reference cycles, compares the period to an expected ratio and flags stuck inputs.
module clk_div_monitor #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             i_ref_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_div_clk,
    input  logic [31:0]      i_exp_ratio,
    output logic [CNT_W-1:0] o_high_cnt,
    output logic [CNT_W-1:0] o_low_cnt,
    output logic [CNT_W-1:0] o_period,
    output logic             o_valid,
    output logic             o_match,
    output logic             o_timeout
);

    localparam int unsigned      PH_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_RISE = 2'd1;
    localparam logic [1:0] MEAS_HIGH = 2'd2;
    localparam logic [1:0] MEAS_LOW  = 2'd3;

    logic             s1_q, s2_q, s3_q;
    logic             rise, fall;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] high_q, high_d, low_q, low_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             load, tmo_hit, phase_last;
    logic [CNT_W:0]   sum_full;
    logic [CNT_W-1:0] sum_sat;

    logic [CNT_W-1:0] high_res_q, low_res_q, period_q;
    logic             valid_q, match_q, timeout_q;

    assign rise       = s2_q & ~s3_q;
    assign fall       = ~s2_q & s3_q;
    assign phase_last = (phase_q >= PH_LAST);

    // Carry out of the widened sum marks a saturated period; such a result never matches.
    assign sum_full = {1'b0, high_q} + {1'b0, low_q};
    assign sum_sat  = sum_full[CNT_W] ? CNT_MAX : sum_full[CNT_W-1:0];

    always_comb begin
        state_d = state_q;
        high_d  = high_q;
        low_d   = low_q;
        phase_d = phase_q;
        load    = 1'b0;
        tmo_hit = 1'b0;
        if (!i_en) begin
            state_d = IDLE;
            high_d  = '0;
            low_d   = '0;
            phase_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_RISE;
                    phase_d = '0;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                        high_d  = CNT_W'(1);
                        low_d   = '0;
                        phase_d = PH_W'(1);
                    end else if (phase_last) begin
                        tmo_hit = 1'b1;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        state_d = MEAS_LOW;
                        low_d   = CNT_W'(1);
                        phase_d = PH_W'(1);
                    end else if (phase_last) begin
                        tmo_hit = 1'b1;
                        state_d = WAIT_RISE;
                        high_d  = '0;
                        low_d   = '0;
                        phase_d = '0;
                    end else begin
                        high_d  = (high_q == CNT_MAX) ? high_q : high_q + CNT_W'(1);
                        phase_d = phase_q + PH_W'(1);
                    end
                end
                MEAS_LOW: begin
                    // The completing rise also opens the next period: no dead cycles.
                    if (rise) begin
                        load    = 1'b1;
                        state_d = MEAS_HIGH;
                        high_d  = CNT_W'(1);
                        low_d   = '0;
                        phase_d = PH_W'(1);
                    end else if (phase_last) begin
                        tmo_hit = 1'b1;
                        state_d = WAIT_RISE;
                        high_d  = '0;
                        low_d   = '0;
                        phase_d = '0;
                    end else begin
                        low_d   = (low_q == CNT_MAX) ? low_q : low_q + CNT_W'(1);
                        phase_d = phase_q + PH_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            state_q    <= IDLE;
            high_q     <= '0;
            low_q      <= '0;
            phase_q    <= '0;
            high_res_q <= '0;
            low_res_q  <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            match_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            s1_q    <= i_div_clk;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            high_q  <= high_d;
            low_q   <= low_d;
            phase_q <= phase_d;
            valid_q <= load;
            if (load) begin
                high_res_q <= high_q;
                low_res_q  <= low_q;
                period_q   <= sum_sat;
                match_q    <= ~sum_full[CNT_W] && (32'(sum_sat) == i_exp_ratio);
                timeout_q  <= 1'b0;
            end else if (tmo_hit) begin
                timeout_q <= 1'b1;
            end else if (!i_en) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign o_high_cnt = high_res_q;
    assign o_low_cnt  = low_res_q;
    assign o_period   = period_q;
    assign o_valid    = valid_q;
    assign o_match    = match_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Self-checking bench for clk_div_monitor: table-driven ratios plus hand sequences for
// timeout, reset, disable and saturation, all checked through result scoreboards.
module tb_clk_div_monitor;

    typedef struct {
        int unsigned h;
        int unsigned l;
        int unsigned p;
        bit          m;
    } exp_t;

    typedef struct {
        int unsigned h;
        int unsigned l;
        int unsigned ratio;
        int unsigned cnt;
        int unsigned eh;
        int unsigned el;
        int unsigned ep;
        bit          em;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, en, div, en_s, div_s;
    logic [31:0] exp_ratio, exp_s;
    logic [15:0] high, low, period;
    logic        valid, match, tmo;
    logic [3:0]  high_s, low_s, period_s;
    logic        valid_s, match_s, tmo_s;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_v = 0;
    int   prev_v = 0;
    exp_t sb_q[$];
    exp_t sbs_q[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    clk_div_monitor #(.CNT_W(16), .TIMEOUT_CYC(16)) dut (
        .i_ref_clk  (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_div_clk  (div),
        .i_exp_ratio(exp_ratio),
        .o_high_cnt (high),
        .o_low_cnt  (low),
        .o_period   (period),
        .o_valid    (valid),
        .o_match    (match),
        .o_timeout  (tmo)
    );

    clk_div_monitor #(.CNT_W(4), .TIMEOUT_CYC(64)) dut_s (
        .i_ref_clk  (clk),
        .i_rst      (rst),
        .i_en       (en_s),
        .i_div_clk  (div_s),
        .i_exp_ratio(exp_s),
        .o_high_cnt (high_s),
        .o_low_cnt  (low_s),
        .o_period   (period_s),
        .o_valid    (valid_s),
        .o_match    (match_s),
        .o_timeout  (tmo_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Every cycle advance goes through here so the scoreboards see each o_valid pulse.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (valid) begin
            n_cmp++;
            prev_v = last_v;
            last_v = cyc;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL valid_unexpected: got o_valid=1 (h=%0d l=%0d p=%0d), required none",
                         high, low, period);
            end else begin
                e = sb_q.pop_front();
                if (high !== 16'(e.h) || low !== 16'(e.l) || period !== 16'(e.p) ||
                    match !== e.m || tmo !== 1'b0) begin
                    n_err++;
                    $display("FAIL result: got h=%0d l=%0d p=%0d m=%0d t=%0d, required h=%0d l=%0d p=%0d m=%0d t=0",
                             high, low, period, match, tmo, e.h, e.l, e.p, e.m);
                end
            end
        end
        if (valid_s) begin
            n_cmp++;
            if (sbs_q.size() == 0) begin
                n_err++;
                $display("FAIL valid_unexpected_sat: got o_valid=1 (p=%0d), required none", period_s);
            end else begin
                e = sbs_q.pop_front();
                if (high_s !== 4'(e.h) || low_s !== 4'(e.l) || period_s !== 4'(e.p) ||
                    match_s !== e.m || tmo_s !== 1'b0) begin
                    n_err++;
                    $display("FAIL result_sat: got h=%0d l=%0d p=%0d m=%0d t=%0d, required h=%0d l=%0d p=%0d m=%0d t=0",
                             high_s, low_s, period_s, match_s, tmo_s, e.h, e.l, e.p, e.m);
                end
            end
        end
    endtask

    task automatic push(input bit sel, input int unsigned h, input int unsigned l,
                        input int unsigned p, input bit m);
        exp_t e;
        e.h = h;
        e.l = l;
        e.p = p;
        e.m = m;
        if (sel) sbs_q.push_back(e);
        else sb_q.push_back(e);
    endtask

    task automatic drv(input bit sel, input logic v);
        if (sel) div_s = v;
        else div = v;
    endtask

    task automatic period_drv(input int unsigned h, input int unsigned l, input bit sel);
        repeat (h) begin tick(); drv(sel, 1'b1); end
        repeat (l) begin tick(); drv(sel, 1'b0); end
    endtask

    // A lone rise long enough for the synchroniser to report it and the load to follow.
    task automatic closing(input bit sel);
        repeat (5) begin tick(); drv(sel, 1'b1); end
    endtask

    task automatic wait_tmo(input int bound);
        for (int i = 0; i < bound && !tmo; i++) tick();
    endtask

    task automatic restart(input logic [31:0] ratio);
        tick();
        en = 1'b0;
        div = 1'b0;
        exp_ratio = ratio;
        repeat (2) tick();
        en = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        vecs[0] = '{h: 2, l: 2, ratio: 4, cnt: 4, eh: 2, el: 2, ep: 4, em: 1'b1};
        vecs[1] = '{h: 2, l: 3, ratio: 4, cnt: 4, eh: 2, el: 3, ep: 5, em: 1'b0};
        vecs[2] = '{h: 4, l: 4, ratio: 8, cnt: 3, eh: 4, el: 4, ep: 8, em: 1'b1};
        vecs[3] = '{h: 3, l: 4, ratio: 7, cnt: 3, eh: 3, el: 4, ep: 7, em: 1'b1};
        vecs[4] = '{h: 1, l: 1, ratio: 2, cnt: 3, eh: 1, el: 1, ep: 2, em: 1'b1};
        vecs[5] = '{h: 5, l: 5, ratio: 9, cnt: 3, eh: 5, el: 5, ep: 10, em: 1'b0};
        vecs[6] = '{h: 1, l: 2, ratio: 3, cnt: 3, eh: 1, el: 2, ep: 3, em: 1'b1};

        rst = 1'b1; en = 1'b0; div = 1'b0; exp_ratio = '0;
        en_s = 1'b0; div_s = 1'b0; exp_s = 32'd15;
        repeat (3) tick();
        chk("reset_outputs", 64'({high, low, period, valid, match, tmo}), 64'd0);
        chk("reset_state", 64'(dut.state_q), 64'd0);
        rst = 1'b0;

        // Input stuck low from enable: timeout while waiting for the first rise.
        exp_ratio = 32'd4;
        en = 1'b1;
        wait_tmo(40);
        chk("stuck_low_timeout", 64'(tmo), 64'd1);
        tick(); en = 1'b0;
        repeat (2) tick();
        chk("disable_clears_timeout", 64'(tmo), 64'd0);

        for (int v = 0; v < 7; v++) begin
            restart(vecs[v].ratio);
            for (int p = 0; p < int'(vecs[v].cnt); p++) begin
                push(1'b0, vecs[v].eh, vecs[v].el, vecs[v].ep, vecs[v].em);
                period_drv(vecs[v].h, vecs[v].l, 1'b0);
            end
            closing(1'b0);
            tick(); en = 1'b0;
            chk("vec_drained", 64'(sb_q.size()), 64'd0);
            chk("vec_interval", 64'(last_v - prev_v), 64'(vecs[v].h + vecs[v].l));
        end

        // Enable mid-high: the partial period before the first rise must not load.
        tick(); en = 1'b0; div = 1'b1; exp_ratio = 32'd4;
        repeat (3) tick();
        en = 1'b1;
        tick();
        repeat (2) begin tick(); div = 1'b0; end
        repeat (3) begin push(1'b0, 2, 2, 4, 1'b1); period_drv(2, 2, 1'b0); end
        closing(1'b0);
        tick(); en = 1'b0;
        chk("partial_drained", 64'(sb_q.size()), 64'd0);

        // Two good periods, then stuck high until timeout, then resume.
        restart(32'd4);
        push(1'b0, 2, 2, 4, 1'b1);
        push(1'b0, 2, 2, 4, 1'b1);
        period_drv(2, 2, 1'b0);
        period_drv(2, 2, 1'b0);
        tick(); div = 1'b1;
        wait_tmo(40);
        chk("stuck_high_timeout", 64'(tmo), 64'd1);
        chk("held_after_timeout", 64'({high, low, period}), 64'({16'd2, 16'd2, 16'd4}));
        chk("drained_before_timeout", 64'(sb_q.size()), 64'd0);
        repeat (2) begin tick(); div = 1'b0; end
        chk("timeout_sticky", 64'(tmo), 64'd1);
        push(1'b0, 2, 2, 4, 1'b1);
        push(1'b0, 2, 2, 4, 1'b1);
        period_drv(2, 2, 1'b0);
        period_drv(2, 2, 1'b0);
        closing(1'b0);
        chk("timeout_cleared_by_load", 64'(tmo), 64'd0);
        tick(); en = 1'b0;

        // Reset pulse while measuring the low phase.
        restart(32'd4);
        push(1'b0, 2, 2, 4, 1'b1);
        period_drv(2, 2, 1'b0);
        repeat (2) begin tick(); div = 1'b1; end
        tick(); div = 1'b0;
        repeat (4) tick();
        chk("in_meas_low", 64'(dut.state_q), 64'd3);
        rst = 1'b1;
        tick();
        chk("mid_reset_outputs", 64'({high, low, period, valid, match, tmo}), 64'd0);
        chk("mid_reset_state", 64'(dut.state_q), 64'd0);
        rst = 1'b0;
        exp_ratio = 32'd8;
        repeat (2) begin push(1'b0, 4, 4, 8, 1'b1); period_drv(4, 4, 1'b0); end
        closing(1'b0);
        tick(); en = 1'b0;
        chk("post_reset_drained", 64'(sb_q.size()), 64'd0);

        // Enable dropped on the cycle the completing rise is detected.
        restart(32'd4);
        push(1'b0, 2, 2, 4, 1'b1);
        period_drv(2, 2, 1'b0);
        period_drv(3, 3, 1'b0);
        tick(); div = 1'b1;
        tick();
        tick(); en = 1'b0;
        tick();
        chk("drop_state_idle", 64'(dut.state_q), 64'd0);
        chk("drop_no_valid", 64'(valid), 64'd0);
        repeat (4) tick();
        chk("drop_results_held", 64'({high, low, period}), 64'({16'd2, 16'd2, 16'd4}));
        chk("drop_drained", 64'(sb_q.size()), 64'd0);

        // Narrow counters: a 20-cycle high phase saturates and never matches.
        en_s = 1'b1;
        repeat (3) tick();
        push(1'b1, 15, 2, 15, 1'b0);
        period_drv(20, 2, 1'b1);
        closing(1'b1);
        tick(); en_s = 1'b0;
        chk("sat_drained", 64'(sbs_q.size()), 64'd0);

        repeat (4) tick();
        chk("final_drained", 64'(sb_q.size() + sbs_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
